// File: rtl/cam_pkg.sv
// Shared camera constants, colour codes and RGB332 field helpers.
// Used by the frame analyser and its pixel classifier.
package cam_pkg;

  localparam int CAM_SCREEN_X = 160;
  localparam int CAM_SCREEN_Y = 120;
  localparam int CAM_NPIX     = CAM_SCREEN_X * CAM_SCREEN_Y;

  typedef enum logic [1:0] {
    COLOR_NONE  = 2'd0,
    COLOR_RED   = 2'd1,
    COLOR_GREEN = 2'd2,
    COLOR_BLUE  = 2'd3
  } color_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_RESULT
  } state_e;

  function automatic logic [2:0] px_r(input logic [7:0] px);
    return px[7:5];
  endfunction

  function automatic logic [2:0] px_g(input logic [7:0] px);
    return px[4:2];
  endfunction

  function automatic logic [1:0] px_b(input logic [7:0] px);
    return px[1:0];
  endfunction

endpackage

// File: rtl/cam_color_stats_classifier.sv
// Combinational RGB332 pixel classifier.
// Outputs are one-hot or all zero.
module rgb332_classifier
  import cam_pkg::*;
#(
  parameter int HI = 5,
  parameter int LO = 2
) (
  input  logic [7:0] px,
  output logic       is_red,
  output logic       is_green,
  output logic       is_blue
);

  localparam logic [2:0] HI3 = 3'(HI);
  localparam logic [2:0] LO3 = 3'(LO);

  logic [2:0] r;
  logic [2:0] g;
  logic [1:0] b;
  logic       r_hi;
  logic       r_lo;
  logic       g_hi;
  logic       g_lo;
  logic       b_lo;
  logic       b_hi;

  assign r = px_r(px);
  assign g = px_g(px);
  assign b = px_b(px);

  assign r_hi = (r >= HI3);
  assign r_lo = (r <= LO3);
  assign g_hi = (g >= HI3);
  assign g_lo = (g <= LO3);
  assign b_lo = (b <= 2'd1);
  assign b_hi = (b == 2'd3);

  assign is_red   = r_hi & g_lo & b_lo;
  assign is_green = g_hi & r_lo & b_lo;
  assign is_blue  = b_hi & r_lo & g_lo;

endmodule

// File: rtl/cam_color_stats.sv
// Frame analyser: scans the capture buffer, counts red/green/blue
// pixels and reports the dominant colour.
module cam_color_stats
  import cam_pkg::*;
#(
  parameter int AW      = 15,
  parameter int NPIX    = cam_pkg::CAM_NPIX,
  parameter int HI      = 5,
  parameter int LO      = 2,
  parameter int MIN_CNT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  output logic [AW-1:0] cnt_red,
  output logic [AW-1:0] cnt_green,
  output logic [AW-1:0] cnt_blue,
  output logic [1:0]    color
);

  localparam logic [AW-1:0] LAST  = AW'(NPIX - 1);
  localparam logic [AW-1:0] MIN_C = AW'(MIN_CNT);

  state_e state;
  logic   vld;
  logic   is_red;
  logic   is_green;
  logic   is_blue;
  logic   red_win;
  logic   grn_win;
  logic   blu_win;
  color_e pick;

  rgb332_classifier #(
    .HI (HI),
    .LO (LO)
  ) u_cls (
    .px       (mem_data),
    .is_red   (is_red),
    .is_green (is_green),
    .is_blue  (is_blue)
  );

  // Ties fall to the earlier colour: red, then green, then blue.
  assign red_win = (cnt_red >= cnt_green) && (cnt_red >= cnt_blue);
  assign grn_win = !red_win && (cnt_green >= cnt_blue);
  assign blu_win = !red_win && !grn_win;

  always_comb begin
    pick = COLOR_NONE;
    unique case (1'b1)
      red_win: if (cnt_red >= MIN_C) pick = COLOR_RED;
      grn_win: if (cnt_green >= MIN_C) pick = COLOR_GREEN;
      blu_win: if (cnt_blue >= MIN_C) pick = COLOR_BLUE;
      default: pick = COLOR_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      vld       <= 1'b0;
      mem_addr  <= '0;
      cnt_red   <= '0;
      cnt_green <= '0;
      cnt_blue  <= '0;
      color     <= COLOR_NONE;
    end else begin
      done <= 1'b0;
      vld  <= 1'b0;
      // mem_data belongs to the address driven one cycle earlier.
      if (vld) begin
        if (is_red)   cnt_red   <= cnt_red + 1'b1;
        if (is_green) cnt_green <= cnt_green + 1'b1;
        if (is_blue)  cnt_blue  <= cnt_blue + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (start && !done) begin
            cnt_red   <= '0;
            cnt_green <= '0;
            cnt_blue  <= '0;
            color     <= COLOR_NONE;
            mem_addr  <= '0;
            busy      <= 1'b1;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          vld <= 1'b1;
          if (mem_addr == LAST) begin
            state <= ST_DRAIN;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          state <= ST_RESULT;
        end
        ST_RESULT: begin
          color <= pick;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_color_stats.sv
// Bench for cam_color_stats: full-size frames plus randomized
// small frames checked against a count-based reference model.
module tb_cam_color_stats;

  localparam int NB = 19200;
  localparam int NS = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_b = 1'b0;
  logic       start_s = 1'b0;

  logic        busy_b, done_b;
  logic [14:0] addr_b, cr_b, cg_b, cb_b;
  logic [1:0]  col_b;
  logic [7:0]  data_b = 8'h00;

  logic        busy_s, done_s;
  logic [8:0]  addr_s, cr_s, cg_s, cb_s;
  logic [1:0]  col_s;
  logic [7:0]  data_s = 8'h00;

  logic [7:0] rom_b [NB];
  logic [7:0] rom_s [NS];

  int compared   = 0;
  int mismatched = 0;

  bit sel = 1'b0;
  logic busy_x, done_x;
  int   addr_x, cr_x, cg_x, cb_x, col_x;

  always #5 clk = ~clk;

  cam_color_stats dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (start_b),
    .busy      (busy_b),
    .done      (done_b),
    .mem_addr  (addr_b),
    .mem_data  (data_b),
    .cnt_red   (cr_b),
    .cnt_green (cg_b),
    .cnt_blue  (cb_b),
    .color     (col_b)
  );

  cam_color_stats #(
    .AW   (9),
    .NPIX (NS)
  ) dut_s (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s),
    .busy      (busy_s),
    .done      (done_s),
    .mem_addr  (addr_s),
    .mem_data  (data_s),
    .cnt_red   (cr_s),
    .cnt_green (cg_s),
    .cnt_blue  (cb_s),
    .color     (col_s)
  );

  always @(posedge clk) begin
    data_b <= rom_b[addr_b];
    data_s <= (int'(addr_s) < NS) ? rom_s[addr_s] : 8'h00;
  end

  always_comb begin
    busy_x = sel ? busy_s : busy_b;
    done_x = sel ? done_s : done_b;
    addr_x = sel ? int'(addr_s) : int'(addr_b);
    cr_x   = sel ? int'(cr_s) : int'(cr_b);
    cg_x   = sel ? int'(cg_s) : int'(cg_b);
    cb_x   = sel ? int'(cb_s) : int'(cb_b);
    col_x  = sel ? int'(col_s) : int'(col_b);
  end

  task automatic check(input string tag, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cls(input logic [7:0] px);
    int r, g, b;
    r = int'(px[7:5]);
    g = int'(px[4:2]);
    b = int'(px[1:0]);
    if (r >= 5 && g <= 2 && b <= 1) return 1;
    if (g >= 5 && r <= 2 && b <= 1) return 2;
    if (b == 3 && r <= 2 && g <= 2) return 3;
    return 0;
  endfunction

  function automatic logic [7:0] rand_px(input int k);
    logic [7:0] v;
    case (k)
      1: v = {3'($urandom_range(5, 7)), 3'($urandom_range(0, 2)),
              2'($urandom_range(0, 1))};
      2: v = {3'($urandom_range(0, 2)), 3'($urandom_range(5, 7)),
              2'($urandom_range(0, 1))};
      3: v = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 2)), 2'd3};
      default: begin
        v = 8'($urandom);
        while (cls(v) != 0) v = 8'($urandom);
      end
    endcase
    return v;
  endfunction

  task automatic model(output int er, output int eg, output int eb,
                       output int ec);
    int n, c, mx;
    logic [7:0] px;
    er = 0; eg = 0; eb = 0;
    n = sel ? NS : NB;
    for (int i = 0; i < n; i++) begin
      if (sel) px = rom_s[i];
      else     px = rom_b[i];
      c = cls(px);
      if (c == 1) er++;
      if (c == 2) eg++;
      if (c == 3) eb++;
    end
    mx = er;
    if (eg > mx) mx = eg;
    if (eb > mx) mx = eb;
    if (er == mx)      ec = 1;
    else if (eg == mx) ec = 2;
    else               ec = 3;
    if (mx < 64) ec = 0;
  endtask

  task automatic set_start(input logic v);
    if (sel) start_s = v;
    else     start_b = v;
  endtask

  task automatic run_scan(input string name, input int ignore_at,
                          input bit start_at_done);
    int er, eg, eb, ec, n, cyc, bad_addr, bad_busy, exp_addr;
    n = sel ? NS : NB;
    model(er, eg, eb, ec);
    @(posedge clk); #1;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    cyc = 0;
    bad_addr = 0;
    bad_busy = 0;
    while (!done_x && cyc < n + 50) begin
      exp_addr = (cyc < n) ? cyc : n - 1;
      if (addr_x != exp_addr) bad_addr++;
      if (!busy_x) bad_busy++;
      set_start(cyc == ignore_at);
      @(posedge clk); #1;
      cyc++;
    end
    set_start(1'b0);
    check({name, "_latency"}, cyc, n + 2);
    check({name, "_addr_seq"}, bad_addr, 0);
    check({name, "_busy_scan"}, bad_busy, 0);
    check({name, "_busy_at_done"}, int'(busy_x), 0);
    check({name, "_red"}, cr_x, er);
    check({name, "_green"}, cg_x, eg);
    check({name, "_blue"}, cb_x, eb);
    check({name, "_color"}, col_x, ec);
    set_start(start_at_done);
    @(posedge clk); #1;
    set_start(1'b0);
    check({name, "_done_width"}, int'(done_x), 0);
    check({name, "_idle_after"}, int'(busy_x), 0);
    @(posedge clk); #1;
    check({name, "_still_idle"}, int'(busy_x), 0);
    check({name, "_hold_red"}, cr_x, er);
    check({name, "_hold_color"}, col_x, ec);
  endtask

  task automatic place(input int cnt, input logic [7:0] v,
                       input logic [7:0] fill);
    int idx;
    for (int i = 0; i < cnt; i++) begin
      idx = $urandom_range(0, NB - 1);
      while (rom_b[idx] != fill) idx = $urandom_range(0, NB - 1);
      rom_b[idx] = v;
    end
  endtask

  task automatic build_small(input int mode);
    int nr, ng, nb, k, p, j;
    logic [7:0] t;
    nr = 0; ng = 0; nb = 0;
    case (mode)
      1: begin
        k = $urandom_range(62, 66);
        nr = k; ng = k; nb = $urandom_range(0, k);
      end
      2: begin
        k = $urandom_range(60, 70);
        ng = k; nb = k; nr = $urandom_range(0, k - 1);
      end
      3: begin
        nr = $urandom_range(0, 50); ng = nr;
        nb = $urandom_range(55, 80);
      end
      default: ;
    endcase
    p = 0;
    for (int i = 0; i < nr; i++) rom_s[p++] = rand_px(1);
    for (int i = 0; i < ng; i++) rom_s[p++] = rand_px(2);
    for (int i = 0; i < nb; i++) rom_s[p++] = rand_px(3);
    while (p < NS) begin
      rom_s[p] = rand_px(mode == 0 ? $urandom_range(0, 3) : 0);
      p++;
    end
    for (int i = NS - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = rom_s[i];
      rom_s[i] = rom_s[j];
      rom_s[j] = t;
    end
  endtask

  initial begin
    int seen;
    sel = 1'b0;
    for (int i = 0; i < NB; i++) rom_b[i] = 8'h00;
    for (int i = 0; i < NS; i++) rom_s[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy_b), 0);
    check("rst_done", int'(done_b), 0);
    check("rst_addr", int'(addr_b), 0);
    check("rst_red", int'(cr_b), 0);
    check("rst_green", int'(cg_b), 0);
    check("rst_blue", int'(cb_b), 0);
    check("rst_color", int'(col_b), 0);
    rst = 1'b0;

    for (int i = 0; i < NB; i++) rom_b[i] = 8'hE0;
    run_scan("t1", -1, 1'b1);
    check("t1_red_abs", cr_x, 19200);
    check("t1_color_abs", col_x, 1);

    for (int i = 0; i < NB; i++)
      rom_b[i] = (i < 100) ? 8'h1C : (i < 150) ? 8'h03 : 8'h00;
    run_scan("t2t5", 500, 1'b0);
    check("t2_green_abs", cg_x, 100);
    check("t2_blue_abs", cb_x, 50);
    check("t2_color_abs", col_x, 2);

    for (int i = 0; i < NB; i++) rom_b[i] = 8'h92;
    place(80, 8'hE0, 8'h92);
    place(80, 8'h1C, 8'h92);
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_busy", int'(busy_b), 0);
    check("t6_done", int'(done_b), 0);
    check("t6_addr", int'(addr_b), 0);
    check("t6_red", int'(cr_b), 0);
    check("t6_green", int'(cg_b), 0);
    check("t6_blue", int'(cb_b), 0);
    check("t6_color", int'(col_b), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done_b || busy_b) seen++;
    end
    check("t6_no_done", seen, 0);

    run_scan("t3", -1, 1'b0);
    check("t3_red_abs", cr_x, 80);
    check("t3_green_abs", cg_x, 80);
    check("t3_color_abs", col_x, 1);

    for (int i = 0; i < NB; i++) rom_b[i] = 8'h00;
    place(10, 8'h03, 8'h00);
    run_scan("t4", -1, 1'b0);
    check("t4_blue_abs", cb_x, 10);
    check("t4_color_abs", col_x, 0);

    sel = 1'b1;
    for (int f = 0; f < 12; f++) begin
      build_small(f % 4);
      run_scan($sformatf("rnd%0d", f), $urandom_range(0, NS - 1), f[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
